// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial shift chain (receive and transmit sides).
// Holds the FSM state encoding and a width helper for counters.
package shift_deser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2, intended for elaboration-time width calculation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_deser_hold.sv
// Output holding register for the deserializer: valid/ready handshake on the
// completed word plus a sticky flag for words dropped while the holder is full.
module shift_deser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic accept_new;
    logic drop_new;

    // A new word may land if the holder is empty or is being drained this edge.
    assign accept_new = word_done && (!out_valid || out_ready);
    assign drop_new   = word_done && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept_new) begin
            out_data  <= word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Setting beats clearing so a drop coinciding with ovr_clr is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop_new) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel capture: assembles WIDTH-bit words from qualified serial
// bits and hands them to shift_deser_hold for the downstream handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; s_valid alone is ignored
// ST_SHIFT | assembling a word; completes one edge after the last bit
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int                CNT_W    = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shifted;
    logic             word_done;

    // A start discards any partial word, so the shift begins from zero.
    always_comb begin
        sr_base = start ? '0 : sr;
        if (MSB_FIRST) begin
            sr_shifted = {sr_base[WIDTH-2:0], s_in};
        end else begin
            sr_shifted = {s_in, sr_base[WIDTH-1:1]};
        end
    end

    assign word_done = (state == ST_SHIFT) && (cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end else if (word_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
    end

    // The full word sits in sr for one cycle while the holder takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (start) begin
            cnt <= s_valid ? CNT_W'(1) : '0;
            sr  <= s_valid ? sr_shifted : '0;
        end else if (word_done) begin
            cnt <= '0;
        end else if ((state == ST_SHIFT) && s_valid) begin
            cnt <= cnt + CNT_W'(1);
            sr  <= sr_shifted;
        end
    end

    shift_deser_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .word      (sr),
        .word_done (word_done),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: MSB-first and LSB-first instances share one stimulus
// stream; expected words are queued as frames are sent and popped on output.
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_in = 1'b0;
    logic       s_valid = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic [7:0] lsb_data;
    logic       lsb_valid;
    logic       lsb_busy;
    logic       lsb_overrun;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] lsb_q[$];
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    shift_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .start(start),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    shift_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .start(start),
        .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(out_ready),
        .busy(lsb_busy), .overrun(lsb_overrun), .ovr_clr(ovr_clr)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Drive one cycle of serial inputs, then sample #1 after the edge.
    task automatic cycle(input logic sv, input logic si, input logic st);
        s_valid = sv;
        s_in    = si;
        start   = st;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    // seq[7] is the first bit on the wire; start rides on the first bit.
    task automatic send_seq(input logic [7:0] seq, input int gap);
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b1, seq[i], (i == 7));
            if (i > 0) repeat (gap) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_ignores_svalid busy=%b exp=0", busy); end
    endtask

    task automatic test_msb_first();
        int busy_cyc;
        logic [7:0] seq;
        seq = 8'b1010_0101;
        out_ready = 1'b1;
        busy_cyc = 0;
        exp_q.push_back(8'hA5);
        lsb_q.push_back(rev8(seq));
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b1, seq[i], (i == 7));
            if (busy === 1'b1) busy_cyc++;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_early_valid got=%b exp=0", out_valid); end
        cycle(1'b0, 1'b0, 1'b0);
        if (busy === 1'b1) busy_cyc++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_w) begin failures++; $display("FAIL msb_data got=%h exp=%h", out_data, exp_w); end
        exp_w = (lsb_q.size() > 0) ? lsb_q.pop_front() : 8'hxx;
        checks++; if (lsb_data !== exp_w) begin failures++; $display("FAIL lsb_palindrome got=%h exp=%h", lsb_data, exp_w); end
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (busy === 1'b1) busy_cyc++;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_consumed valid=%b exp=0", out_valid); end
        checks++; if (busy_cyc !== 8) begin failures++; $display("FAIL msb_busy_cycles got=%0d exp=8", busy_cyc); end
    endtask

    task automatic test_lsb_gapped();
        logic [7:0] seqs[2];
        seqs[0] = 8'b1100_0000;
        seqs[1] = 8'b1010_0101;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lsb_q.push_back(rev8(seqs[k]));
            exp_q.push_back(seqs[k]);
            send_seq(seqs[k], 2);
            checks++; if (lsb_valid !== 1'b0) begin failures++; $display("FAIL lsb_early_valid[%0d] got=%b exp=0", k, lsb_valid); end
            cycle(1'b0, 1'b0, 1'b0);
            exp_w = (lsb_q.size() > 0) ? lsb_q.pop_front() : 8'hxx;
            checks++; if (lsb_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid[%0d] got=%b exp=1", k, lsb_valid); end
            checks++; if (lsb_data !== exp_w) begin failures++; $display("FAIL lsb_data[%0d] got=%h exp=%h", k, lsb_data, exp_w); end
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (out_data !== exp_w) begin failures++; $display("FAIL msb_gapped_data[%0d] got=%h exp=%h", k, out_data, exp_w); end
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_seq(8'h3C, 0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun); end
        send_seq(8'hF0, 0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL ovr_hold_data got=%h exp=%h", out_data, exp_q[0]); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        ovr_clr = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        // Drop coinciding with ovr_clr: the set must win.
        send_seq(8'h77, 0);
        ovr_clr = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        ovr_clr = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        out_ready = 1'b1;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_data !== exp_w) begin failures++; $display("FAIL ovr_consume_data got=%h exp=%h", out_data, exp_w); end
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_consumed valid=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_seq(8'h11, 0);
        cycle(1'b0, 1'b0, 1'b0);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_data !== exp_w || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=%h/1", out_data, out_valid, exp_w); end
        send_seq(8'h22, 0);
        out_ready = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_w) begin failures++; $display("FAIL b2b_second got=%h exp=%h", out_data, exp_w); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
        out_ready = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain valid=%b exp=0", out_valid); end
    endtask

    task automatic test_restart();
        int extra;
        out_ready = 1'b1;
        extra = 0;
        cycle(1'b1, 1'b1, 1'b1);
        repeat (4) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (out_valid === 1'b1) extra++;
        end
        exp_q.push_back(8'h5A);
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b1, 8'h5A >> i, (i == 7));
            if (out_valid === 1'b1) extra++;
        end
        cycle(1'b0, 1'b0, 1'b0);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin failures++; $display("FAIL restart_word got=%h/%b exp=%h/1", out_data, out_valid, exp_w); end
        repeat (4) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (out_valid === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL restart_extra_valid got=%0d exp=0", extra); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL restart_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", out_data); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", busy, out_valid, overrun);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(8'hC3);
        send_seq(8'hC3, 0);
        cycle(1'b0, 1'b0, 1'b0);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin failures++; $display("FAIL midrst_word got=%h/%b exp=%h/1", out_data, out_valid, exp_w); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gapped();
        test_overrun();
        test_back_to_back();
        test_restart();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-to-parallel capture block, the receive side of the team's serial shift chain.
- Samples a serial bit stream on qualified clock edges and assembles WIDTH-bit words.
- Presents each completed word on a holding register with a valid/ready handshake to downstream control logic.
- Reports dropped words through a sticky overrun flag.

Parameters:
WIDTH, 8, number of bits per word (2..32)
MSB_FIRST, 1, 1 = first received bit lands in data[WIDTH-1]; 0 = first bit lands in data[0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s_in  input  1  serial data bit
s_valid  input  1  s_in is sampled on this edge when high
start  input  1  single-cycle frame start; begins a new word
out_data  output  WIDTH  completed word (holding register)
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid & out_ready
busy  output  1  word assembly in progress
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit count=0, shift register=0, out_data=0, out_valid=0, busy=0, overrun=0.
- FSM states:
  - IDLE: busy=0; s_valid without start is ignored.
  - SHIFT: busy=1.
- IDLE -> SHIFT on start.
  - If s_valid is high in the start cycle, that bit is captured as bit 0 of the word and the count becomes 1.
  - Otherwise the count becomes 0.
- In SHIFT, each s_valid cycle shifts s_in into the shift register and increments the count. Cycles without s_valid hold all state.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters the LSB.
  - MSB_FIRST=0: shift right, new bit enters the MSB.
  - Either way, after WIDTH bits the first-received bit sits at the position defined by MSB_FIRST.
- Word completion: the s_valid cycle that delivers bit WIDTH-1.
  - On the next edge the assembled word goes to out_data, out_valid goes 1, and the FSM returns to IDLE.
  - Latency from last-bit sample edge to out_valid high: 1 cycle.
  - With WIDTH=8 and start coincident with the first s_valid, 8 consecutive s_valid cycles give out_valid on the 9th edge.
- start while in SHIFT: the partial word is discarded and a new word begins. Count rules are the same as IDLE->SHIFT. No flag is raised.
- Handshake:
  - out_valid & out_ready at an edge clears out_valid, unless a new word completes on the same edge.
  - out_data is stable while out_valid=1 and out_ready=0.
- Completion while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged, overrun is set to 1. The FSM still returns to IDLE.
- Completion while out_valid=1 and out_ready=1: the old word is consumed, the new word is loaded, out_valid stays 1, and there is no overrun.
- overrun stays set until ovr_clr.
  - If ovr_clr and a new overrun occur in the same cycle, set wins.
- The count never wraps. It resets to 0 on completion or start, and its width is clog2(WIDTH)+1.
- rst_n asserted mid-word: immediate return to reset values; the partial word is lost.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package holds the FSM state encoding (ST_IDLE, ST_SHIFT, 1-bit) and a clog2 helper function used for the count width. The package is shared with the parallel-to-serial side.
- Sub-module shift_deser_hold: the out_data/out_valid holding register, handshake and overrun logic. Inputs: word, word_done, out_ready, ovr_clr. The top level keeps the FSM, counter and shift register.

Test Plan:
- MSB_FIRST=1, WIDTH=8: start+s_valid with bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, out_ready=1 -> out_data=0xA5 and out_valid=1 one cycle after the last bit, cleared next cycle; busy high for exactly 8 cycles.
- MSB_FIRST=0, same bit stream with s_valid gapped (1 cycle on, 2 off) -> out_data=0xA5 bit-reversed = 0xA5 (palindrome), so repeat with bits 1,1,0,0,0,0,0,0 -> 0x03; no spurious shifts during gaps.
- out_ready=0, two complete words 0x3C then 0xF0 -> out_data holds 0x3C, overrun=1 after the second word; ovr_clr pulse -> overrun=0; out_ready=1 -> 0x3C consumed.
- Back-to-back words with out_ready asserted on the completion edge of word 2 (0x11 then 0x22) -> out_valid stays 1, out_data 0x11 then 0x22, overrun=0.
- Restart: start, 5 bits, start again, then 8 bits of 0x5A -> single word 0x5A, no overrun, no extra out_valid.
- rst_n low for 1 cycle after 4 bits, then a full 0xC3 frame -> all outputs 0 during reset; next word 0xC3 captured correctly.
